// File: rtl/fetch_prefetch_unit.sv
// Purpose : instruction fetch stage; issues word-aligned IMEM requests, queues {pc, instr}
//           responses in order, and flushes/squashes everything on a redirect.
// Latency : request register to IMEM_REQ_VALID 1 cycle; response to INSTR_VALID_out 1 cycle
//           (redirect at t -> new request at t+1 -> head valid at t+3 with 1-cycle memory).
// Backpressure: IMEM request held stable until accepted; new requests only issued when a
//           FIFO slot is guaranteed for the response; decode stalls via INSTR_READY_in.
// Ports:
//   CLK, RST                        clock, async active-high reset
//   EN, REDIRECT_in, REDIRECT_PC_in fetch enable and redirect pulse/target
//   IMEM_REQ_VALID/READY/ADDR       request handshake
//   IMEM_RSP_VALID/DATA             in-order response, never stalled
//   INSTR_VALID_out/READY_in,
//   INSTR_out, PC_out               prefetch FIFO head towards decode
module fetch_prefetch_unit #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 4,
    parameter int              MAX_OUTST  = 2
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            EN,
    input  logic            REDIRECT_in,
    input  logic [XLEN-1:0] REDIRECT_PC_in,
    output logic            IMEM_REQ_VALID,
    input  logic            IMEM_REQ_READY,
    output logic [XLEN-1:0] IMEM_REQ_ADDR,
    input  logic            IMEM_RSP_VALID,
    input  logic [31:0]     IMEM_RSP_DATA,
    output logic            INSTR_VALID_out,
    input  logic            INSTR_READY_in,
    output logic [31:0]     INSTR_out,
    output logic [XLEN-1:0] PC_out
);
    localparam int OW = $clog2(MAX_OUTST + 1);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);

    logic            req_q;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] rsp_pc;
    logic [OW-1:0]   outst;
    logic [OW-1:0]   drop;
    logic [CW-1:0]   count;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [XLEN-1:0] pc_mem    [FIFO_DEPTH];
    logic [31:0]     instr_mem [FIFO_DEPTH];

    logic            hs;
    logic            push;
    logic            pop;
    logic [XLEN-1:0] redirect_pc;
    logic [OW-1:0]   outst_nxt;
    logic [OW-1:0]   drop_nxt;
    logic [CW-1:0]   count_nxt;
    logic            credit_ok;
    logic            req_nxt;

    // A pending request is withdrawn in the redirect cycle so the stale address never handshakes.
    assign IMEM_REQ_VALID = req_q & ~REDIRECT_in;
    assign IMEM_REQ_ADDR  = fetch_pc;
    assign hs             = IMEM_REQ_VALID & IMEM_REQ_READY;
    assign push           = IMEM_RSP_VALID & (drop == '0) & ~REDIRECT_in;
    assign pop            = INSTR_VALID_out & INSTR_READY_in & ~REDIRECT_in;
    assign redirect_pc    = REDIRECT_PC_in & ~XLEN'(3);

    always_comb begin
        outst_nxt = outst + OW'(hs) - OW'(IMEM_RSP_VALID);
        count_nxt = count + CW'(push) - CW'(pop);
        drop_nxt  = drop;
        if (REDIRECT_in) begin
            count_nxt = '0;
            // Every request still unanswered after this cycle belongs to the old stream.
            drop_nxt  = outst_nxt;
        end else if (IMEM_RSP_VALID && (drop != '0)) begin
            drop_nxt  = drop - OW'(1);
        end
        // Credit check on next-cycle occupancy: each in-flight response owns a FIFO slot.
        credit_ok = (int'(outst_nxt) < MAX_OUTST) &&
                    ((int'(outst_nxt) + int'(count_nxt)) < FIFO_DEPTH);
        if (req_q && !hs && !REDIRECT_in) begin
            req_nxt = 1'b1;
        end else begin
            req_nxt = EN && credit_ok;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            req_q    <= 1'b0;
            fetch_pc <= RESET_PC;
            rsp_pc   <= RESET_PC;
            outst    <= '0;
            drop     <= '0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            req_q <= req_nxt;
            outst <= outst_nxt;
            drop  <= drop_nxt;
            count <= count_nxt;
            if (REDIRECT_in) begin
                fetch_pc <= redirect_pc;
                rsp_pc   <= redirect_pc;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                if (hs) begin
                    fetch_pc <= fetch_pc + XLEN'(4);
                end
                if (push) begin
                    rsp_pc <= rsp_pc + XLEN'(4);
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
            end
        end
    end

    // Storage needs no reset: entries are only visible while count says they are valid.
    always_ff @(posedge CLK) begin
        if (push) begin
            pc_mem[wr_ptr]    <= rsp_pc;
            instr_mem[wr_ptr] <= IMEM_RSP_DATA;
        end
    end

    assign INSTR_VALID_out = (count != '0);
    assign INSTR_out       = INSTR_VALID_out ? instr_mem[rd_ptr] : 32'h0;
    assign PC_out          = INSTR_VALID_out ? pc_mem[rd_ptr] : '0;

    rsp_needs_outst: assert property (@(posedge CLK) disable iff (RST)
        IMEM_RSP_VALID |-> (outst != '0));
    no_push_when_full: assert property (@(posedge CLK) disable iff (RST)
        push |-> (count != CW'(FIFO_DEPTH)));
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
module tb_fetch_prefetch_unit;
    logic        CLK = 1'b0;
    logic        RST;
    logic        EN;
    logic        REDIRECT_in;
    logic [31:0] REDIRECT_PC_in;
    logic        IMEM_REQ_READY;
    logic        IMEM_RSP_VALID;
    logic [31:0] IMEM_RSP_DATA;
    logic        INSTR_READY_in;

    logic        req_vld, ivld, w2_req_vld, w2_ivld;
    logic [31:0] req_addr, instr, pc, w2_req_addr, w2_instr, w2_pc;

    always #5 CLK = ~CLK;

    fetch_prefetch_unit #(.XLEN(32), .RESET_PC(32'h0), .FIFO_DEPTH(4), .MAX_OUTST(2)) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .REDIRECT_in(REDIRECT_in), .REDIRECT_PC_in(REDIRECT_PC_in),
        .IMEM_REQ_VALID(req_vld), .IMEM_REQ_READY(IMEM_REQ_READY), .IMEM_REQ_ADDR(req_addr),
        .IMEM_RSP_VALID(IMEM_RSP_VALID), .IMEM_RSP_DATA(IMEM_RSP_DATA),
        .INSTR_VALID_out(ivld), .INSTR_READY_in(INSTR_READY_in), .INSTR_out(instr), .PC_out(pc));

    // Same stimulus, reset PC one word below zero: its addresses trail the main unit by 4.
    fetch_prefetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(4), .MAX_OUTST(2)) dut_wrap (
        .CLK(CLK), .RST(RST), .EN(EN), .REDIRECT_in(REDIRECT_in), .REDIRECT_PC_in(REDIRECT_PC_in),
        .IMEM_REQ_VALID(w2_req_vld), .IMEM_REQ_READY(IMEM_REQ_READY), .IMEM_REQ_ADDR(w2_req_addr),
        .IMEM_RSP_VALID(IMEM_RSP_VALID), .IMEM_RSP_DATA(IMEM_RSP_DATA),
        .INSTR_VALID_out(w2_ivld), .INSTR_READY_in(INSTR_READY_in), .INSTR_out(w2_instr), .PC_out(w2_pc));

    int n_cmp = 0;
    int n_bad = 0;
    int cyc;
    int lat;
    logic [31:0] mq_addr[$];
    int          mq_due[$];

    typedef struct {
        logic        en, rrdy, irdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_ivld;
        logic [31:0] e_pc;
    } vec_t;
    vec_t tbl[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (cycle %0d): got 0x%08h, expected 0x%08h", name, cyc, act, exp);
        end
    endtask

    // Memory model: responds in order, lat cycles after acceptance, data = ~address.
    task automatic drive_rsp();
        if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
            IMEM_RSP_VALID = 1'b1;
            IMEM_RSP_DATA  = ~mq_addr[0];
        end else begin
            IMEM_RSP_VALID = 1'b0;
            IMEM_RSP_DATA  = 32'h0;
        end
    endtask

    task automatic tick();
        if (req_vld && IMEM_REQ_READY) begin
            mq_addr.push_back(req_addr);
            mq_due.push_back(cyc + lat);
        end
        if (IMEM_RSP_VALID) begin
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end
        @(posedge CLK);
        cyc++;
        @(negedge CLK);
        drive_rsp();
    endtask

    task automatic do_reset(input int l);
        RST = 1'b1;
        EN = 1'b0; REDIRECT_in = 1'b0; REDIRECT_PC_in = 32'h0;
        IMEM_REQ_READY = 1'b1; INSTR_READY_in = 1'b1;
        IMEM_RSP_VALID = 1'b0; IMEM_RSP_DATA = 32'h0;
        mq_addr.delete(); mq_due.delete();
        lat = l;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        cyc = 0;
        drive_rsp();
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " req_vld"}, {31'b0, req_vld}, 32'h0);
        chk({tag, " addr"}, req_addr, 32'h0);
        chk({tag, " ivld"}, {31'b0, ivld}, 32'h0);
        chk({tag, " instr"}, instr, 32'h0);
        chk({tag, " pc"}, pc, 32'h0);
        chk({tag, " wrap addr"}, w2_req_addr, 32'hFFFF_FFFC);
        chk({tag, " wrap ivld"}, {31'b0, w2_ivld}, 32'h0);
    endtask

    initial begin
        int found;
        int got;
        //          en rr ir  req addr          ivld pc
        tbl[0]  = '{1, 1, 1,  0, 32'h00,        0, 32'h00};
        tbl[1]  = '{1, 1, 1,  1, 32'h00,        0, 32'h00};
        tbl[2]  = '{1, 1, 1,  1, 32'h04,        0, 32'h00};
        tbl[3]  = '{1, 1, 1,  1, 32'h08,        1, 32'h00};
        tbl[4]  = '{1, 1, 0,  1, 32'h0C,        1, 32'h04};
        tbl[5]  = '{1, 1, 0,  1, 32'h10,        1, 32'h04};
        tbl[6]  = '{1, 1, 0,  0, 32'h14,        1, 32'h04};
        tbl[7]  = '{1, 1, 1,  0, 32'h14,        1, 32'h04};
        tbl[8]  = '{1, 1, 1,  1, 32'h14,        1, 32'h08};
        tbl[9]  = '{1, 1, 1,  1, 32'h18,        1, 32'h0C};
        tbl[10] = '{0, 1, 1,  1, 32'h1C,        1, 32'h10};
        tbl[11] = '{0, 1, 1,  0, 32'h20,        1, 32'h14};
        tbl[12] = '{0, 1, 1,  0, 32'h20,        1, 32'h18};
        tbl[13] = '{0, 1, 1,  0, 32'h20,        1, 32'h1C};
        tbl[14] = '{0, 1, 1,  0, 32'h20,        0, 32'h00};

        RST = 1'b1; EN = 1'b0; REDIRECT_in = 1'b0; REDIRECT_PC_in = 32'h0;
        IMEM_REQ_READY = 1'b0; INSTR_READY_in = 1'b0; IMEM_RSP_VALID = 1'b0; IMEM_RSP_DATA = 32'h0;
        cyc = 0; lat = 1;
        @(posedge CLK);
        #1;
        chk_reset("reset");

        // Streaming with 1-cycle memory, decode stall, then EN dropped.
        do_reset(1);
        for (int i = 0; i < 15; i++) begin
            EN = tbl[i].en; IMEM_REQ_READY = tbl[i].rrdy; INSTR_READY_in = tbl[i].irdy;
            #1;
            chk($sformatf("v%0d req_vld", i), {31'b0, req_vld}, {31'b0, tbl[i].e_req});
            chk($sformatf("v%0d addr", i), req_addr, tbl[i].e_addr);
            chk($sformatf("v%0d ivld", i), {31'b0, ivld}, {31'b0, tbl[i].e_ivld});
            chk($sformatf("v%0d pc", i), pc, tbl[i].e_pc);
            chk($sformatf("v%0d instr", i), instr, tbl[i].e_ivld ? ~tbl[i].e_pc : 32'h0);
            chk($sformatf("v%0d wrap req_vld", i), {31'b0, w2_req_vld}, {31'b0, tbl[i].e_req});
            chk($sformatf("v%0d wrap addr", i), w2_req_addr, tbl[i].e_addr - 32'h4);
            chk($sformatf("v%0d wrap pc", i), w2_pc, tbl[i].e_ivld ? tbl[i].e_pc - 32'h4 : 32'h0);
            chk($sformatf("v%0d wrap instr", i), w2_instr, tbl[i].e_ivld ? ~tbl[i].e_pc : 32'h0);
            tick();
        end

        // Request held stable while memory stalls, then accepted exactly once.
        do_reset(1);
        EN = 1'b1; IMEM_REQ_READY = 1'b0;
        #1; tick();
        for (int i = 1; i <= 5; i++) begin
            #1;
            chk($sformatf("stall%0d req_vld", i), {31'b0, req_vld}, 32'h1);
            chk($sformatf("stall%0d addr", i), req_addr, 32'h0);
            tick();
        end
        IMEM_REQ_READY = 1'b1;
        #1; chk("stall accept addr", req_addr, 32'h0); tick();
        IMEM_REQ_READY = 1'b0;
        #1; chk("stall next addr", req_addr, 32'h4); tick();
        #1; chk("stall head ivld", {31'b0, ivld}, 32'h1); chk("stall head pc", pc, 32'h0); tick();
        #1; chk("stall single entry", {31'b0, ivld}, 32'h0);

        // Two fetches in flight (0x10, 0x14) squashed by redirect to 0x103.
        do_reset(3);
        EN = 1'b1;
        found = 0;
        for (int k = 0; k < 40 && found == 0; k++) begin
            #1;
            if (mq_addr.size() == 2 && mq_addr[0] == 32'h10 && mq_addr[1] == 32'h14) found = 1;
            else tick();
        end
        chk("squash two in flight", found, 1);
        REDIRECT_in = 1'b1; REDIRECT_PC_in = 32'h103;
        #1; chk("squash req forced off", {31'b0, req_vld}, 32'h0);
        tick();
        REDIRECT_in = 1'b0;
        got = 0;
        for (int k = 0; k < 20 && got == 0; k++) begin
            #1;
            if (ivld) begin
                got = 1;
                chk("squash first pc", pc, 32'h100);
                chk("squash first instr", instr, ~32'h100);
            end else begin
                tick();
            end
        end
        chk("squash head arrives", got, 1);

        // Redirect coinciding with response, pop and a pending request.
        do_reset(1);
        EN = 1'b1;
        repeat (4) begin #1; tick(); end
        #1;
        chk("rdr pre ivld", {31'b0, ivld}, 32'h1);
        chk("rdr pre req pending", {31'b0, IMEM_RSP_VALID & req_vld}, 32'h1);
        REDIRECT_in = 1'b1; REDIRECT_PC_in = 32'h202;
        #1; chk("rdr req forced off", {31'b0, req_vld}, 32'h0);
        tick();
        REDIRECT_in = 1'b0;
        #1;
        chk("rdr t+1 ivld", {31'b0, ivld}, 32'h0);
        chk("rdr t+1 req_vld", {31'b0, req_vld}, 32'h1);
        chk("rdr t+1 addr", req_addr, 32'h200);
        tick();
        #1; chk("rdr t+2 ivld", {31'b0, ivld}, 32'h0); tick();
        #1;
        chk("rdr t+3 ivld", {31'b0, ivld}, 32'h1);
        chk("rdr t+3 pc", pc, 32'h200);
        chk("rdr t+3 instr", instr, ~32'h200);
        tick();

        // Decode stalled: FIFO fills to exactly four, requests stop, then drains in order.
        do_reset(1);
        EN = 1'b1; INSTR_READY_in = 1'b0;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (i >= 5) chk($sformatf("fill%0d req_vld", i), {31'b0, req_vld}, 32'h0);
            tick();
        end
        EN = 1'b0; INSTR_READY_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("drain%0d ivld", i), {31'b0, ivld}, 32'h1);
            chk($sformatf("drain%0d pc", i), pc, 32'(4 * i));
            tick();
        end
        #1;
        chk("drain empty", {31'b0, ivld}, 32'h0);
        chk("drain no req", {31'b0, req_vld}, 32'h0);

        // Reset asserted mid-burst.
        do_reset(1);
        EN = 1'b1;
        repeat (5) begin #1; tick(); end
        #2;
        RST = 1'b1;
        #1;
        chk_reset("midrst");
        do_reset(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end
endmodule
